vga_stream_tx: RTL and testbench

- Terminating end of the processed-pixel stream. Receives the valid-qualified RGB stream that the image processing pipeline emits, buffers it in a FIFO, and re-times it onto VGA raster timing (HS/VS/BLANK_N, RGB).
- Replaces the simulation-only image dumper when the design runs on hardware.
- Frame alignment uses a start-of-frame marker.
- Underflow resynchronises the block at the next frame.

---
 rtl/vga_stream_tx.sv | 174 +++++++++++++++++
 tb/tb_vga_stream_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_tx.sv
// vga_stream_tx: buffers a valid-qualified RGB stream and replays it on
// VGA raster timing, locking to a start-of-frame marker.
module vga_stream_tx #(
   parameter int PIXEL_DEPTH = 8,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int FIFO_AW     = 10,
   parameter int START_LEVEL = 640
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   pix_en,
   input  logic [PIXEL_DEPTH-1:0] raw_VGA_R,
   input  logic [PIXEL_DEPTH-1:0] raw_VGA_G,
   input  logic [PIXEL_DEPTH-1:0] raw_VGA_B,
   input  logic                   valid_i,
   input  logic                   sof_i,
   output logic [PIXEL_DEPTH-1:0] VGA_R,
   output logic [PIXEL_DEPTH-1:0] VGA_G,
   output logic [PIXEL_DEPTH-1:0] VGA_B,
   output logic                   VGA_HS,
   output logic                   VGA_VS,
   output logic                   VGA_BLANK_N,
   output logic                   ready_o,
   output logic                   locked,
   output logic                   underflow,
   output logic                   overflow,
   output logic [FIFO_AW:0]       fifo_level
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DEPTH   = 2 ** FIFO_AW;
   localparam int DW      = 3 * PIXEL_DEPTH;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_ONE  = HW'(1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_ONE  = VW'(1);

   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   LVL_ONE = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0]   FULL_C  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   START_C = (FIFO_AW + 1)'(START_LEVEL);

   localparam logic [1:0] WAIT_SOF = 2'd0;
   localparam logic [1:0] PRIME    = 2'd1;
   localparam logic [1:0] RUN      = 2'd2;

   logic [HW-1:0]      h_cnt;
   logic [VW-1:0]      v_cnt;
   logic [1:0]         state;
   logic [DW-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [DW-1:0]      rd_data;

   logic active;
   logic hs_n;
   logic vs_n;
   logic full;
   logic empty;
   logic push_req;
   logic pop_req;
   logic flush;
   logic push_ok;
   logic pop_ok;
   logic frame_end;

   always_comb begin
      active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_n      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs_n      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      full      = (fifo_level == FULL_C);
      empty     = (fifo_level == '0);
      push_req  = valid_i && ((state != WAIT_SOF) || sof_i);
      pop_req   = pix_en && active && (state == RUN);
      flush     = pop_req && empty;
      pop_ok    = pop_req && !empty;
      // the flush cycle discards any incoming pixel, sof included
      push_ok   = push_req && !full && !flush;
      frame_end = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      rd_data   = mem[rd_ptr];
   end

   assign ready_o = !full;
   assign locked  = (state == RUN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) v_cnt <= '0;
            else v_cnt <= v_cnt + V_ONE;
         end else begin
            h_cnt <= h_cnt + H_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else if (pix_en) begin
         VGA_BLANK_N <= active;
         VGA_HS      <= hs_n;
         VGA_VS      <= vs_n;
         if (pop_ok) {VGA_R, VGA_G, VGA_B} <= rd_data;
         else {VGA_R, VGA_G, VGA_B} <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {raw_VGA_R, raw_VGA_G, raw_VGA_B};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push_req && full) overflow <= 1'b1;
         if (flush) begin
            underflow  <= 1'b1;
            rd_ptr     <= wr_ptr;
            fifo_level <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok) fifo_level <= fifo_level + LVL_ONE;
            else if (pop_ok && !push_ok) fifo_level <= fifo_level - LVL_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= WAIT_SOF;
      end else begin
         case (state)
            WAIT_SOF: if (valid_i && sof_i) state <= PRIME;
            PRIME:    if (frame_end && (fifo_level >= START_C)) state <= RUN;
            RUN:      if (flush) state <= WAIT_SOF;
            default:  state <= WAIT_SOF;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_stream_tx.sv
// tb_vga_stream_tx: small-raster bench with a queue-based reference model,
// a table of overflow vectors and directed lock/underflow/reset sequences.
module tb_vga_stream_tx;

   localparam int PD = 8;
   localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
   localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
   localparam int AW = 4, SL = 4;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int DEPTH = 2 ** AW;
   localparam logic [35:0] RST_VEC = {24'h0, 7'b0111000, 5'd0};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic pix_en = 1'b0;
   logic [PD-1:0] raw_VGA_R = '0, raw_VGA_G = '0, raw_VGA_B = '0;
   logic valid_i = 1'b0, sof_i = 1'b0;
   logic [PD-1:0] VGA_R, VGA_G, VGA_B;
   logic VGA_HS, VGA_VS, VGA_BLANK_N;
   logic ready_o, locked, underflow, overflow;
   logic [AW:0] fifo_level;
   logic [35:0] dut_vec;

   always #5 clk = ~clk;

   vga_stream_tx #(
      .PIXEL_DEPTH(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .FIFO_AW(AW), .START_LEVEL(SL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
      .raw_VGA_R(raw_VGA_R), .raw_VGA_G(raw_VGA_G), .raw_VGA_B(raw_VGA_B),
      .valid_i(valid_i), .sof_i(sof_i),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .ready_o(ready_o), .locked(locked),
      .underflow(underflow), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   assign dut_vec = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS,
                     ready_o, locked, underflow, overflow, fifo_level};

   int errors = 0;
   int checks = 0;

   // reference model: tick count, pixel queue, mode 0=wait 1=prime 2=run
   int m_t, m_state, last_t, last_h, last_v;
   logic [23:0] q[$];
   bit m_under, m_over;
   logic [23:0] e_rgb;
   bit e_blank, e_hs, e_vs;

   logic [7:0] seen[$];
   int lock_t, lock_h, lock_v;
   bit prev_locked;

   typedef struct {
      bit valid;
      bit sof;
      logic [7:0] r;
      int exp_level;
      bit exp_over;
      bit exp_ready;
   } ovf_vec_t;
   ovf_vec_t tbl[18];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] exp_vec();
      return {e_rgb, e_blank, e_hs, e_vs, (q.size() != DEPTH),
              (m_state == 2), m_under, m_over, 5'(q.size())};
   endfunction

   function automatic void model_reset();
      m_t = 0; m_state = 0; q.delete();
      m_under = 0; m_over = 0;
      e_rgb = '0; e_blank = 0; e_hs = 1; e_vs = 1;
      seen.delete(); lock_t = -1; prev_locked = 0;
   endfunction

   function automatic void model_step(bit pe, bit v, bit s, logic [23:0] px);
      int h, ln, sz;
      bit act, popreq, flush, pushreq, prime_go;
      h = m_t % HT;
      ln = (m_t / HT) % VT;
      sz = q.size();
      last_t = m_t; last_h = h; last_v = ln;
      popreq = 0; flush = 0;
      if (pe) begin
         act = (h < HA) && (ln < VA);
         e_blank = act;
         e_hs = !((h >= HA + HF) && (h < HA + HF + HSY));
         e_vs = !((ln >= VA + VF) && (ln < VA + VF + VSY));
         popreq = (m_state == 2) && act;
         flush = popreq && (sz == 0);
         e_rgb = (popreq && sz > 0) ? q[0] : 24'h0;
      end
      pushreq = v && (m_state != 0 || s);
      prime_go = pe && m_state == 1 && h == HT - 1 && ln == VT - 1 && sz >= SL;
      if (flush) begin
         q.delete(); m_under = 1; m_state = 0;
      end else begin
         if (popreq) void'(q.pop_front());
         if (pushreq) begin
            if (sz == DEPTH) m_over = 1;
            else q.push_back(px);
         end
         if (m_state == 0 && v && s) m_state = 1;
         else if (prime_go) m_state = 2;
      end
      if (pe) m_t++;
   endfunction

   task automatic cycle(bit pe, bit v, bit s, logic [23:0] px);
      pix_en = pe; valid_i = v; sof_i = s;
      {raw_VGA_R, raw_VGA_G, raw_VGA_B} = px;
      @(posedge clk);
      model_step(pe, v, s, px);
      @(negedge clk);
      check($sformatf("model_t%0d", last_t), dut_vec, exp_vec());
      if (locked && !prev_locked && lock_t < 0) begin
         lock_t = last_t; lock_h = last_h; lock_v = last_v;
      end
      prev_locked = locked;
      if (VGA_BLANK_N && locked) seen.push_back(VGA_R);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 24'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 0; pix_en = 0; valid_i = 0; sof_i = 0;
      {raw_VGA_R, raw_VGA_G, raw_VGA_B} = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", dut_vec, RST_VEC);
      reset_n = 1;
   endtask

   function automatic logic [23:0] pix(int r);
      return {8'(r), 8'($urandom), 8'($urandom)};
   endfunction

   initial begin
      for (int i = 0; i < 18; i++) begin
         tbl[i].valid = 1;
         tbl[i].sof = (i == 0);
         tbl[i].r = 8'(i);
         tbl[i].exp_level = (i + 1 > DEPTH) ? DEPTH : i + 1;
         tbl[i].exp_over = (i >= DEPTH);
         tbl[i].exp_ready = (tbl[i].exp_level < DEPTH);
      end

      // nominal frame
      do_reset();
      for (int i = 0; i < 12; i++) cycle(1, 1, i == 0, pix(i));
      idle(79);
      check("t1_lock_pos", 64'(lock_h * 16 + lock_v), 64'(7 * 16 + 5));
      check("t1_count", 64'(seen.size()), 64'd12);
      for (int i = 0; i < seen.size() && i < 12; i++)
         check($sformatf("t1_r%0d", i), 64'(seen[i]), 64'(i));
      check("t1_underflow", 64'(underflow), 64'd0);

      // pixels before sof are dropped
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, pix(100 + i));
         check("t2_level0", 64'(fifo_level), 64'd0);
      end
      for (int i = 0; i < 12; i++) cycle(1, 1, i == 0, pix(50 + i));
      idle(60);
      check("t2_first_r", (seen.size() > 0) ? 64'(seen[0]) : 64'hx, 64'd50);

      // underflow and relock
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1, 1, i == 0, pix(i));
      for (int k = 0; k < 120 && !underflow; k++) idle(1);
      check("t3_uf_pos", 64'(last_h * 16 + last_v), 64'(2 * 16 + 1));
      check("t3_uf_pins", {VGA_R, locked, underflow, fifo_level},
            {8'd0, 1'b0, 1'b1, 5'd0});
      lock_t = -1;
      for (int i = 0; i < 12; i++) cycle(1, 1, i == 0, pix(i));
      for (int k = 0; k < 150 && lock_t < 0; k++) idle(1);
      check("t3_relock_tick", 64'(lock_t), 64'd95);

      // overflow with timing frozen, table-driven
      do_reset();
      for (int i = 0; i < 18; i++) begin
         cycle(0, tbl[i].valid, tbl[i].sof, pix(tbl[i].r));
         check($sformatf("t4_vec%0d", i), {overflow, ready_o, fifo_level},
               {tbl[i].exp_over, tbl[i].exp_ready, 5'(tbl[i].exp_level)});
      end
      for (int k = 0; k < 200 && !underflow; k++) idle(1);
      check("t4_underflow", 64'(underflow), 64'd1);
      check("t4_count", 64'(seen.size()), 64'd16);
      for (int i = 0; i < seen.size() && i < 16; i++)
         check($sformatf("t4_r%0d", i), 64'(seen[i]), 64'(i));

      // one push per pop keeps the level flat
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 1, i == 0, pix(i));
      idle(44);
      for (int k = 0; k < 50; k++) begin
         bit act;
         act = ((m_t % HT) < HA) && (((m_t / HT) % VT) < VA);
         cycle(1, act, 0, pix(20 + k));
         if (act) check($sformatf("t5_level_t%0d", last_t),
                        64'(fifo_level), 64'd4);
      end

      // asynchronous reset mid-line
      check("t6_pre_locked", 64'(locked), 64'd1);
      @(posedge clk);
      #3 reset_n = 0;
      #1 check("t6_async_reset", dut_vec, RST_VEC);
      pix_en = 0; valid_i = 0; sof_i = 0;
      @(negedge clk);
      model_reset();
      reset_n = 1;
      for (int i = 0; i < 20; i++) cycle(1, 1, 0, pix(i));
      idle(40);
      check("t6_nolock", {locked, fifo_level}, 6'd0);
      for (int i = 0; i < 12; i++) cycle(1, 1, i == 0, pix(i));
      for (int k = 0; k < 100 && lock_t < 0; k++) idle(1);
      check("t6_relock_tick", 64'(lock_t), 64'd95);

      // randomized traffic against the model
      for (int blk = 0; blk < 5; blk++) begin
         int vprob;
         vprob = 15 + 12 * blk;
         do_reset();
         for (int k = 0; k < 300; k++)
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < vprob,
                  $urandom_range(0, 19) == 0,
                  24'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
